rtc_clock_core: RTL and testbench
=================================

Name: rtc_clock_core

Overview:
- Parametrised successor to the team's HH:MM:SS digital clock.
- Divides the system clock down to a 1 Hz tick and keeps 24-hour time in binary counters.
- Adds run/pause control, validated time load, a 12/24-hour display mode, and a day-rollover pulse.
- Sits between the board clock and the display/BCD formatting logic; an optional alarm comparator is compiled in by macro.

Parameters:
- TICKS_PER_SEC, 50000000: clk cycles per second. Must be >= 2. Benches use a small value.
- PRESC_W, 26: prescaler counter width. Must satisfy 2**PRESC_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- run  input  1  1 = time advances; 0 = prescaler and counters hold
- mode_12h  input  1  display format select: 1 = 12-hour, 0 = 24-hour
- set_en  input  1  single-cycle load strobe
- set_hh  input  5  load hours, 0..23
- set_mm  input  6  load minutes, 0..59
- set_ss  input  6  load seconds, 0..59
- seconds  output  6  current seconds, 0..59
- minutes  output  6  current minutes, 0..59
- hours  output  5  current hours, always 24-hour, 0..23
- disp_hours  output  5  display hours: 0..23 when mode_12h=0; 1..12 when mode_12h=1
- pm  output  1  1 when hours >= 12 (valid in both modes)
- sec_tick  output  1  one-cycle pulse on every seconds advance
- day_tick  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
- set_err  output  1  one-cycle pulse when a load request is rejected
- alarm_en  input  1  alarm arm
- alarm_hh  input  5  alarm hours
- alarm_mm  input  6  alarm minutes
- alarm_hit  output  1  one-cycle alarm pulse

Behaviour:
- Reset: asynchronous and active-high. While rst=1, all of the following are 0:
  - prescaler, seconds, minutes, hours, sec_tick, day_tick, set_err, alarm_hit
  - disp_hours=0 (mode_12h=0) or 12 (mode_12h=1); pm=0
  - Reset mid-count or mid-load discards all state.
- Prescaler:
  - With run=1, counts 0..TICKS_PER_SEC-1 and wraps to 0.
  - At terminal count (TICKS_PER_SEC-1) with run=1, an internal tick is generated.
  - With run=0, the prescaler holds its value; no tick.
- Tick handling: all registered; outputs change on the edge where the prescaler wraps.
  - sec_tick=1 for exactly that following cycle.
  - seconds 59->0 carries into minutes; minutes 59->0 carries into hours; hours 23->0.
  - The full carry chain resolves in a single cycle.
  - day_tick=1 in the same cycle that 00:00:00 first appears via a tick.
  - Period check: first tick after reset occurs TICKS_PER_SEC cycles after rst deasserts, then every TICKS_PER_SEC cycles while run=1.
- Load, when set_en=1:
  - Legal only if set_hh<=23, set_mm<=59 and set_ss<=59.
  - Legal load: next edge loads all three counters and clears the prescaler to 0. No sec_tick, no day_tick.
  - Illegal load: counters and prescaler unchanged; set_err=1 for one cycle.
  - A load has priority over a simultaneous tick; that tick is dropped.
  - Load works regardless of run.
- Display (combinational from hours and mode_12h):
  - pm = (hours >= 12).
  - mode_12h=1: hours 0 -> 12; 1..12 -> unchanged; 13..23 -> hours-12.
  - mode_12h=0: disp_hours = hours.
  - Toggling mode_12h never alters the counters.
- All arithmetic is unsigned. Counters never hold out-of-range values.

Optional Feature:
- Macro: RTC_CLOCK_ALARM_EN.
- Defined:
  - alarm_hit=1 for one cycle, coincident with the sec_tick that makes the counters equal alarm_hh:alarm_mm:00, when alarm_en=1.
  - A load landing on the alarm time does not fire.
  - An alarm_hh or alarm_mm value that is out of range never matches.
- Undefined:
  - Comparator not built; alarm_hit is tied to 0.
  - alarm_en, alarm_hh and alarm_mm are ignored. The ports remain present.

Test Plan (TICKS_PER_SEC=4):
- Reset, run=1: first sec_tick 4 cycles after rst falls, then every 4 cycles; after 60 ticks, minutes=1 and seconds=0.
- Load 23:59:58, run=1: after 2 ticks, time is 00:00:00 with day_tick=1 for exactly one cycle, coincident with sec_tick.
- set_en with 24:00:00, then with 12:60:00: set_err pulses once per request; time unchanged.
- Load 12:34:56 asserted on a tick cycle: time reads 12:34:56, no sec_tick; next tick comes 4 cycles later at 12:34:57. Repeat with run=0: time holds 12:34:56 indefinitely.
- mode_12h=1 at hours 0, 11, 12, 13, 23: disp_hours/pm = 12/0, 11/0, 12/1, 1/1, 11/1. Assert rst mid-count: all outputs 0 immediately, without waiting for a clock edge.
- RTC_CLOCK_ALARM_EN defined, alarm 07:30, load 07:29:58: alarm_hit pulses once 2 ticks later. Alarm 07:30 with load 07:30:00 directly: no pulse. Macro undefined: alarm_hit stays 0 throughout.

Source files
------------

// File: rtl/rtc_clock_core.sv
// 24-hour real-time clock core: prescaler down to a 1 Hz tick, HH:MM:SS counters, validated load, 12/24-hour display.
// Optional alarm comparator is compiled in when RTC_CLOCK_ALARM_EN is defined.
module rtc_clock_core #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_en,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic [5:0] set_ss,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [4:0] disp_hours,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       set_err,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    output logic       alarm_hit
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [5:0]         seconds_reg, seconds_next;
    logic [5:0]         minutes_reg, minutes_next;
    logic [4:0]         hours_reg, hours_next;
    logic               sec_tick_reg, sec_tick_next;
    logic               day_tick_reg, day_tick_next;
    logic               set_err_reg, set_err_next;
    logic               set_legal;

    assign set_legal = (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);

    // A load request (legal or not) owns the cycle; a coincident tick is dropped.
    always_comb begin
        presc_next    = presc_reg;
        seconds_next  = seconds_reg;
        minutes_next  = minutes_reg;
        hours_next    = hours_reg;
        sec_tick_next = 1'b0;
        day_tick_next = 1'b0;
        set_err_next  = 1'b0;
        if (set_en) begin
            if (set_legal) begin
                presc_next   = '0;
                seconds_next = set_ss;
                minutes_next = set_mm;
                hours_next   = set_hh;
            end else begin
                set_err_next = 1'b1;
            end
        end else if (run) begin
            if (presc_reg == PRESC_MAX) begin
                presc_next    = '0;
                sec_tick_next = 1'b1;
                if (seconds_reg == 6'd59) begin
                    seconds_next = 6'd0;
                    if (minutes_reg == 6'd59) begin
                        minutes_next = 6'd0;
                        if (hours_reg == 5'd23) begin
                            hours_next    = 5'd0;
                            day_tick_next = 1'b1;
                        end else begin
                            hours_next = hours_reg + 5'd1;
                        end
                    end else begin
                        minutes_next = minutes_reg + 6'd1;
                    end
                end else begin
                    seconds_next = seconds_reg + 6'd1;
                end
            end else begin
                presc_next = presc_reg + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg    <= '0;
            seconds_reg  <= '0;
            minutes_reg  <= '0;
            hours_reg    <= '0;
            sec_tick_reg <= 1'b0;
            day_tick_reg <= 1'b0;
            set_err_reg  <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            seconds_reg  <= seconds_next;
            minutes_reg  <= minutes_next;
            hours_reg    <= hours_next;
            sec_tick_reg <= sec_tick_next;
            day_tick_reg <= day_tick_next;
            set_err_reg  <= set_err_next;
        end
    end

`ifdef RTC_CLOCK_ALARM_EN
    logic alarm_hit_reg, alarm_hit_next;
    logic alarm_match;

    // Compare against the time that the tick is about to produce, so only a tick can fire it.
    assign alarm_match = alarm_en && (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59) &&
                         (hours_next == alarm_hh) && (minutes_next == alarm_mm) &&
                         (seconds_next == 6'd0);
    assign alarm_hit_next = sec_tick_next && alarm_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_hit_reg <= 1'b0;
        end else begin
            alarm_hit_reg <= alarm_hit_next;
        end
    end

    assign alarm_hit = alarm_hit_reg;
`else
    logic alarm_unused;
    assign alarm_unused = ^{alarm_en, alarm_hh, alarm_mm};
    assign alarm_hit    = 1'b0;
`endif

    always_comb begin
        disp_hours = hours_reg;
        if (mode_12h) begin
            if (hours_reg == 5'd0) begin
                disp_hours = 5'd12;
            end else if (hours_reg > 5'd12) begin
                disp_hours = hours_reg - 5'd12;
            end
        end
    end

    assign pm       = (hours_reg >= 5'd12);
    assign seconds  = seconds_reg;
    assign minutes  = minutes_reg;
    assign hours    = hours_reg;
    assign sec_tick = sec_tick_reg;
    assign day_tick = day_tick_reg;
    assign set_err  = set_err_reg;

endmodule

// File: tb/tb_rtc_clock_core.sv
// Directed bench for rtc_clock_core with TICKS_PER_SEC=4; expected values are hand-computed.
module tb_rtc_clock_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_hh = '0;
    logic [5:0] set_mm = '0;
    logic [5:0] set_ss = '0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [4:0] disp_hours;
    logic       pm;
    logic       sec_tick;
    logic       day_tick;
    logic       set_err;
    logic       alarm_en = 1'b0;
    logic [4:0] alarm_hh = '0;
    logic [5:0] alarm_mm = '0;
    logic       alarm_hit;

    int vectors = 0;
    int miscompares = 0;

`ifdef RTC_CLOCK_ALARM_EN
    localparam int ALARM_PULSES = 1;
`else
    localparam int ALARM_PULSES = 0;
`endif

    rtc_clock_core #(.TICKS_PER_SEC(4), .PRESC_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .mode_12h(mode_12h),
        .set_en(set_en), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .seconds(seconds), .minutes(minutes), .hours(hours),
        .disp_hours(disp_hours), .pm(pm), .sec_tick(sec_tick),
        .day_tick(day_tick), .set_err(set_err),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_time(input string tag, input int hh, input int mm, input int ss);
        check({tag, ".hh"}, int'(hours), hh);
        check({tag, ".mm"}, int'(minutes), mm);
        check({tag, ".ss"}, int'(seconds), ss);
    endtask

    // Called and returns at a falling edge; pulses are counted at each falling edge.
    task automatic run_cycles(input int n, output int st, output int dt, output int ah);
        st = 0; dt = 0; ah = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st += int'(sec_tick);
            dt += int'(day_tick);
            ah += int'(alarm_hit);
        end
    endtask

    task automatic do_load(input int hh, input int mm, input int ss);
        set_hh = 5'(hh); set_mm = 6'(mm); set_ss = 6'(ss);
        set_en = 1'b1;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    initial begin
        int st, dt, ah;
        int hrs[5]    = '{0, 11, 12, 13, 23};
        int exp_d[5]  = '{12, 11, 12, 1, 11};
        int exp_pm[5] = '{0, 0, 1, 1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check_time("reset", 0, 0, 0);
        check("reset.sec_tick", int'(sec_tick), 0);
        check("reset.disp24", int'(disp_hours), 0);
        mode_12h = 1'b1;
        #1 check("reset.disp12", int'(disp_hours), 12);
        check("reset.pm", int'(pm), 0);
        mode_12h = 1'b0;
        @(negedge clk);

        // First tick 4 cycles after reset release, then 59 more in 236 cycles
        run = 1'b1;
        rst = 1'b0;
        run_cycles(3, st, dt, ah);
        check("first.early_ticks", st, 0);
        @(negedge clk);
        check("first.sec_tick", int'(sec_tick), 1);
        check("first.ss", int'(seconds), 1);
        run_cycles(236, st, dt, ah);
        check("minute.ticks", st, 59);
        check("minute.last_tick", int'(sec_tick), 1);
        check_time("minute", 0, 1, 0);
        $display("step: 60 ticks -> %0d:%0d:%0d", hours, minutes, seconds);

        // Day rollover
        do_load(23, 59, 58);
        check_time("load_2359", 23, 59, 58);
        check("load_2359.sec_tick", int'(sec_tick), 0);
        run_cycles(8, st, dt, ah);
        check("rollover.ticks", st, 2);
        check("rollover.day_ticks", dt, 1);
        check("rollover.day_tick", int'(day_tick), 1);
        check("rollover.sec_tick", int'(sec_tick), 1);
        check_time("rollover", 0, 0, 0);
        @(negedge clk);
        check("rollover.day_tick_clear", int'(day_tick), 0);
        $display("step: rollover -> %0d:%0d:%0d", hours, minutes, seconds);

        // Illegal loads
        run = 1'b0;
        do_load(24, 0, 0);
        check("bad_hh.set_err", int'(set_err), 1);
        check_time("bad_hh", 0, 0, 0);
        @(negedge clk);
        check("bad_hh.set_err_clear", int'(set_err), 0);
        do_load(12, 60, 0);
        check("bad_mm.set_err", int'(set_err), 1);
        check_time("bad_mm", 0, 0, 0);
        @(negedge clk);
        check("bad_mm.set_err_clear", int'(set_err), 0);
        $display("step: illegal loads rejected");

        // Load coinciding with a tick drops the tick and restarts the prescaler
        run = 1'b1;
        do_load(12, 0, 0);
        run_cycles(3, st, dt, ah);
        check("pretick.ticks", st, 0);
        do_load(12, 34, 56);
        check_time("load_on_tick", 12, 34, 56);
        check("load_on_tick.sec_tick", int'(sec_tick), 0);
        run_cycles(3, st, dt, ah);
        check("after_load.early_ticks", st, 0);
        @(negedge clk);
        check("after_load.sec_tick", int'(sec_tick), 1);
        check_time("after_load", 12, 34, 57);
        $display("step: load on tick -> %0d:%0d:%0d", hours, minutes, seconds);

        // Paused: load works, time holds
        run = 1'b0;
        do_load(12, 34, 56);
        run_cycles(20, st, dt, ah);
        check("paused.ticks", st, 0);
        check_time("paused", 12, 34, 56);
        $display("step: paused -> %0d:%0d:%0d", hours, minutes, seconds);

        // 12-hour display
        mode_12h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_load(hrs[i], 0, 0);
            check($sformatf("disp12.h%0d", hrs[i]), int'(disp_hours), exp_d[i]);
            check($sformatf("pm.h%0d", hrs[i]), int'(pm), exp_pm[i]);
            check($sformatf("hours.h%0d", hrs[i]), int'(hours), hrs[i]);
            $display("step: hours=%0d disp=%0d pm=%0d", hours, disp_hours, pm);
        end
        mode_12h = 1'b0;
        #1 check("disp24.h23", int'(disp_hours), 23);
        check("mode_toggle.hours", int'(hours), 23);

        // Asynchronous reset mid-count
        @(negedge clk);
        run = 1'b1;
        mode_12h = 1'b1;
        do_load(13, 14, 15);
        run_cycles(6, st, dt, ah);
        #2 rst = 1'b1;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst.disp", int'(disp_hours), 12);
        check("async_rst.pm", int'(pm), 0);
        check("async_rst.sec_tick", int'(sec_tick), 0);
        @(negedge clk);
        rst = 1'b0;
        mode_12h = 1'b0;
        $display("step: async reset -> %0d:%0d:%0d", hours, minutes, seconds);

        // Alarm
        alarm_en = 1'b1;
        alarm_hh = 5'd7;
        alarm_mm = 6'd30;
        do_load(7, 29, 58);
        run_cycles(8, st, dt, ah);
        check("alarm.pulses", ah, ALARM_PULSES);
        check("alarm.hit_now", int'(alarm_hit), ALARM_PULSES);
        check_time("alarm", 7, 30, 0);
        do_load(7, 30, 0);
        check("alarm_load.hit", int'(alarm_hit), 0);
        run_cycles(6, st, dt, ah);
        check("alarm_load.pulses", ah, 0);
        $display("step: alarm -> %0d:%0d:%0d", hours, minutes, seconds);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
